// File: rtl/xnor_accum.sv
// xnor_accum
// Sequential XNOR-popcount accumulator for the binary MLP datapath. Each
// accepted beat of packed binary activations/weights (1 = +1, 0 = -1) adds
// its bipolar dot product, 2*popcount(~(act ^ wgt)) - WORD_W, to a 15-bit
// signed running sum. When a neuron finishes, the sum is presented on accum1
// (layer 1, full width) or accum2 (layer 2, saturated to 7 bits). The layer
// is chosen by l1_in at start.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start, l1_in        begin a neuron (IDLE only); layer select 1 = L1, 0 = L2
//   act, wgt, in_valid  input beat; accepted when in_valid & in_ready
//   in_ready            high while accumulating
//   l1                  layer flag of the current/last result
//   accum1, accum2      layer-1 / layer-2 results, two's complement
//   out_valid           result available; consumed when out_valid & out_ready
//   out_ready           consumer ready
module xnor_accum #(
   parameter int unsigned WORD_W   = 16,
   parameter int unsigned L1_BEATS = 49,
   parameter int unsigned L2_BEATS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              l1_in,
   input  logic [WORD_W-1:0] act,
   input  logic [WORD_W-1:0] wgt,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              l1,
   output logic [14:0]       accum1,
   output logic [6:0]        accum2,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned MaxBeats = (L1_BEATS > L2_BEATS) ? L1_BEATS : L2_BEATS;
   localparam int unsigned CntW     = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
   localparam int unsigned PopW     = $clog2(WORD_W + 1);

   localparam logic [CntW-1:0] L1Last = CntW'(L1_BEATS - 1);
   localparam logic [CntW-1:0] L2Last = CntW'(L2_BEATS - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_t;

   state_t             r_state;
   logic [CntW-1:0]    r_cnt;
   logic signed [14:0] r_sum;
   logic               r_l1;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [14:0]        r_accum1;
   logic [6:0]         r_accum2;

   logic [WORD_W-1:0]  w_xnor;
   logic [PopW-1:0]    w_pop;
   logic signed [14:0] w_beat;
   logic signed [14:0] w_sum_next;
   logic [6:0]         w_sat;
   logic               w_last;

   // Per-beat bipolar partial sum: agreements count +1, disagreements -1.
   always_comb begin
      w_xnor = ~(act ^ wgt);
      w_pop  = '0;
      for (int i = 0; i < int'(WORD_W); i++) begin
         w_pop = w_pop + PopW'(w_xnor[i]);
      end
      w_beat     = signed'(15'({w_pop, 1'b0})) - signed'(15'(WORD_W));
      w_sum_next = r_sum + w_beat;
   end

   always_comb begin
      if (w_sum_next > 15'sd63) begin
         w_sat = 7'h3F;
      end else if (w_sum_next < -15'sd64) begin
         w_sat = 7'h40;
      end else begin
         w_sat = w_sum_next[6:0];
      end
   end

   assign w_last = (r_cnt == (r_l1 ? L1Last : L2Last));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_l1        <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_accum1    <= '0;
         r_accum2    <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_l1       <= l1_in;
                  r_sum      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_state    <= StAccum;
               end
            end
            StAccum: begin
               if (in_valid) begin
                  r_sum <= w_sum_next;
                  r_cnt <= r_cnt + CntW'(1);
                  if (w_last) begin
                     // Results are captured from the sum including this last beat.
                     if (r_l1) begin
                        r_accum1 <= w_sum_next;
                     end else begin
                        r_accum2 <= w_sat;
                     end
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= StDone;
                  end
               end
            end
            StDone: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign l1        = r_l1;
   assign accum1    = r_accum1;
   assign accum2    = r_accum2;

endmodule

// File: tb/tb_xnor_accum.sv
// Bench for xnor_accum: a default instance (L2_BEATS=3) and a second one
// with L2_BEATS=5 for the saturation cases; sel5 steers stimulus to one of them.
module tb_xnor_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        l1_in = 1'b0;
   logic [15:0] act = '0;
   logic [15:0] wgt = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        sel5 = 1'b0;

   logic        start0, start5, iv0, iv5;
   logic        ir0, ir5, ov0, ov5, l10, l15;
   logic [14:0] a10, a15;
   logic [6:0]  a20, a25;

   logic        w_in_ready, w_out_valid, w_l1;
   logic [14:0] w_a1;
   logic [6:0]  w_a2;

   int n_pass = 0;
   int n_checks = 0;

   logic [15:0] q_act[$];
   logic [15:0] q_wgt[$];
   logic [14:0] exp_a1[2];
   logic [6:0]  exp_a2[2];

   always #5 clk = ~clk;

   assign start0 = start & ~sel5;
   assign start5 = start & sel5;
   assign iv0    = in_valid & ~sel5;
   assign iv5    = in_valid & sel5;

   assign w_in_ready  = sel5 ? ir5 : ir0;
   assign w_out_valid = sel5 ? ov5 : ov0;
   assign w_l1        = sel5 ? l15 : l10;
   assign w_a1        = sel5 ? a15 : a10;
   assign w_a2        = sel5 ? a25 : a20;

   xnor_accum dut0 (
      .clk(clk), .rst(rst), .start(start0), .l1_in(l1_in), .act(act), .wgt(wgt),
      .in_valid(iv0), .in_ready(ir0), .l1(l10), .accum1(a10), .accum2(a20),
      .out_valid(ov0), .out_ready(out_ready)
   );

   xnor_accum #(.L2_BEATS(5)) dut5 (
      .clk(clk), .rst(rst), .start(start5), .l1_in(l1_in), .act(act), .wgt(wgt),
      .in_valid(iv5), .in_ready(ir5), .l1(l15), .accum1(a15), .accum2(a25),
      .out_valid(ov5), .out_ready(out_ready)
   );

   // Reference model: bipolar dot product counted bit by bit.
   function automatic int model_sum(input int n);
      int s = 0;
      for (int b = 0; b < n; b++) begin
         for (int i = 0; i < 16; i++) begin
            if (q_act[b][i] == q_wgt[b][i]) s += 1;
            else s -= 1;
         end
      end
      return s;
   endfunction

   function automatic logic [6:0] sat7(input int s);
      if (s > 63) return 7'h3F;
      else if (s < -64) return 7'h40;
      else return 7'(s);
   endfunction

   task automatic fill_const(input int n, input logic [15:0] a, input logic [15:0] w);
      q_act.delete();
      q_wgt.delete();
      for (int i = 0; i < n; i++) begin
         q_act.push_back(a);
         q_wgt.push_back(w);
      end
   endtask

   task automatic fill_rand(input int n);
      q_act.delete();
      q_wgt.delete();
      for (int i = 0; i < n; i++) begin
         q_act.push_back(16'($urandom));
         q_wgt.push_back(16'($urandom));
      end
   endtask

   task automatic do_start(input logic l1v);
      start = 1'b1;
      l1_in = l1v;
      @(posedge clk); #1;
      start = 1'b0;
      l1_in = 1'b0;
   endtask

   // Offer n beats; mode 0 = always valid, 1 = every other cycle, 2 = random.
   // A stray start with l1_in=0 is pulsed when beat index stray_at is offered.
   task automatic feed(input int n, input int mode, input int stray_at,
                       output int accepted, output bit early);
      int budget;
      bit tog;
      bit fire;
      accepted = 0;
      early    = 1'b0;
      budget   = 4 * n + 20;
      tog      = 1'b1;
      while (accepted < n && budget > 0) begin
         case (mode)
            1:       in_valid = tog;
            2:       in_valid = 1'($urandom_range(0, 1));
            default: in_valid = 1'b1;
         endcase
         tog = ~tog;
         act = q_act[accepted];
         wgt = q_wgt[accepted];
         start = (accepted == stray_at);
         l1_in = 1'b0;
         if (w_out_valid) early = 1'b1;
         fire = in_valid && w_in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (fire) accepted++;
         budget--;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (w_out_valid !== 1'b0 || w_in_ready !== 1'b0)
         $display("FAIL drain_idle out_valid=%b in_ready=%b required 0/0", w_out_valid, w_in_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      #12;
      rst = 1'b1;
      #1;
      n_checks++;
      if (ir0 !== 1'b0 || ov0 !== 1'b0) $display("FAIL reset_hs in_ready=%b out_valid=%b required 0/0", ir0, ov0);
      else n_pass++;
      n_checks++;
      if (a10 !== 15'd0 || a20 !== 7'd0) $display("FAIL reset_accum accum1=%h accum2=%h required 0/0", a10, a20);
      else n_pass++;
      n_checks++;
      if (l10 !== 1'b0) $display("FAIL reset_l1 l1=%b required 0", l10);
      else n_pass++;
      n_checks++;
      if (ir5 !== 1'b0 || ov5 !== 1'b0 || a15 !== 15'd0 || a25 !== 7'd0 || l15 !== 1'b0)
         $display("FAIL reset_dut5 ir=%b ov=%b a1=%h a2=%h l1=%b required all 0", ir5, ov5, a15, a25, l15);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_a1[0] = '0; exp_a1[1] = '0; exp_a2[0] = '0; exp_a2[1] = '0;
      @(posedge clk); #1;
   endtask

   // Layer-1 neuron on dut0; mode selects bubble pattern.
   task automatic test_l1(input string name, input int mode);
      int acc;
      bit early;
      sel5 = 1'b0;
      do_start(1'b1);
      n_checks++;
      if (w_in_ready !== 1'b1) $display("FAIL %s_in_ready got=%b required 1", name, w_in_ready);
      else n_pass++;
      feed(49, mode, -1, acc, early);
      exp_a1[0] = 15'(model_sum(49));
      n_checks++;
      if (acc != 49 || early) $display("FAIL %s_beats accepted=%0d early_valid=%0b required 49/0", name, acc, early);
      else n_pass++;
      n_checks++;
      if (w_out_valid !== 1'b1 || w_in_ready !== 1'b0)
         $display("FAIL %s_done out_valid=%b in_ready=%b required 1/0", name, w_out_valid, w_in_ready);
      else n_pass++;
      n_checks++;
      if (w_a1 !== exp_a1[0]) $display("FAIL %s_accum1 got=%h required %h", name, w_a1, exp_a1[0]);
      else n_pass++;
      n_checks++;
      if (w_l1 !== 1'b1 || w_a2 !== exp_a2[0])
         $display("FAIL %s_l1_accum2 l1=%b accum2=%h required 1/%h", name, w_l1, w_a2, exp_a2[0]);
      else n_pass++;
      drain();
   endtask

   task automatic test_layer2();
      logic [15:0] ta[4] = '{16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0000};
      logic [15:0] tw[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
      bit          ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int acc;
      bit early;
      int n;
      int k;
      for (int c = 0; c < 4; c++) begin
         sel5 = ts[c];
         k = int'(ts[c]);
         n = ts[c] ? 5 : 3;
         fill_const(n, ta[c], tw[c]);
         do_start(1'b0);
         feed(n, 0, -1, acc, early);
         exp_a2[k] = sat7(model_sum(n));
         n_checks++;
         if (acc != n || early || w_out_valid !== 1'b1)
            $display("FAIL l2_case%0d_beats accepted=%0d early=%0b out_valid=%b required %0d/0/1",
                     c, acc, early, w_out_valid, n);
         else n_pass++;
         n_checks++;
         if (w_a2 !== exp_a2[k]) $display("FAIL l2_case%0d_accum2 got=%h required %h", c, w_a2, exp_a2[k]);
         else n_pass++;
         n_checks++;
         if (w_a1 !== exp_a1[k] || w_l1 !== 1'b0)
            $display("FAIL l2_case%0d_hold accum1=%h l1=%b required %h/0", c, w_a1, w_l1, exp_a1[k]);
         else n_pass++;
         drain();
      end
      sel5 = 1'b0;
   endtask

   task automatic test_backpressure();
      int acc;
      bit early;
      sel5 = 1'b0;
      fill_rand(49);
      do_start(1'b1);
      feed(49, 2, 5, acc, early);
      exp_a1[0] = 15'(model_sum(49));
      n_checks++;
      if (acc != 49 || early) $display("FAIL bp_beats accepted=%0d early=%0b required 49/0", acc, early);
      else n_pass++;
      for (int cyc = 0; cyc < 5; cyc++) begin
         n_checks++;
         if (w_out_valid !== 1'b1 || w_a1 !== exp_a1[0] || w_l1 !== 1'b1 || w_in_ready !== 1'b0)
            $display("FAIL bp_hold%0d out_valid=%b accum1=%h l1=%b in_ready=%b required 1/%h/1/0",
                     cyc, w_out_valid, w_a1, w_l1, w_in_ready, exp_a1[0]);
         else n_pass++;
         out_ready = 1'b0;
         start = (cyc == 2);
         l1_in = 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
      end
      drain();
   endtask

   task automatic test_random();
      int acc;
      bit early;
      bit l1v;
      int n;
      int k;
      for (int it = 0; it < 8; it++) begin
         sel5 = 1'($urandom_range(0, 1));
         k = int'(sel5);
         l1v = 1'($urandom_range(0, 1));
         n = l1v ? 49 : (sel5 ? 5 : 3);
         fill_rand(n);
         do_start(l1v);
         feed(n, int'($urandom_range(0, 2)), -1, acc, early);
         if (l1v) exp_a1[k] = 15'(model_sum(n));
         else exp_a2[k] = sat7(model_sum(n));
         n_checks++;
         if (acc != n || early || w_out_valid !== 1'b1)
            $display("FAIL rand%0d_beats accepted=%0d early=%0b out_valid=%b required %0d/0/1",
                     it, acc, early, w_out_valid, n);
         else n_pass++;
         n_checks++;
         if (w_a1 !== exp_a1[k] || w_a2 !== exp_a2[k] || w_l1 !== l1v)
            $display("FAIL rand%0d_result accum1=%h accum2=%h l1=%b required %h/%h/%b",
                     it, w_a1, w_a2, w_l1, exp_a1[k], exp_a2[k], l1v);
         else n_pass++;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         drain();
      end
      sel5 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int acc;
      bit early;
      bit seen;
      sel5 = 1'b0;
      fill_const(49, 16'hFFFF, 16'hFFFF);
      do_start(1'b1);
      feed(10, 0, -1, acc, early);
      rst = 1'b1;
      #1;
      n_checks++;
      if (ir0 !== 1'b0 || ov0 !== 1'b0 || a10 !== 15'd0 || l10 !== 1'b0)
         $display("FAIL rstmid_abort in_ready=%b out_valid=%b accum1=%h l1=%b required 0/0/0/0",
                  ir0, ov0, a10, l10);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_a1[0] = '0; exp_a1[1] = '0; exp_a2[0] = '0; exp_a2[1] = '0;
      seen = 1'b0;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (w_out_valid || w_in_ready) seen = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++;
      if (seen) $display("FAIL rstmid_quiet activity=%b required 0", seen);
      else n_pass++;
      do_start(1'b1);
      feed(49, 0, -1, acc, early);
      exp_a1[0] = 15'(model_sum(49));
      n_checks++;
      if (acc != 49 || early || w_out_valid !== 1'b1 || w_a1 !== exp_a1[0])
         $display("FAIL rstmid_fresh accepted=%0d early=%0b out_valid=%b accum1=%h required 49/0/1/%h",
                  acc, early, w_out_valid, w_a1, exp_a1[0]);
      else n_pass++;
      drain();
   endtask

   initial begin
      test_reset();
      fill_const(49, 16'hFFFF, 16'hFFFF);
      test_l1("l1_agree", 0);
      fill_const(49, 16'h0000, 16'hFFFF);
      test_l1("l1_disagree", 1);
      test_layer2();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/xnor_accum.md
# xnor_accum

Sequential XNOR-popcount accumulator that produces the per-neuron layer-1 sum (15-bit) and layer-2 sum (7-bit) consumed by the downstream accumulator-select mux in the binary MLP datapath. Packed binary activation/weight words stream in under a valid/ready handshake. Each beat contributes a bipolar partial sum. The finished result is presented on the port matching the layer selected at start, under an output valid/ready handshake.

## Interface
- WORD_W, 16: bits per activation/weight beat.
- L1_BEATS, 49: beats per layer-1 neuron (784 inputs).
- L2_BEATS, 3: beats per layer-2 neuron (48 inputs).
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a neuron; honoured only in IDLE.
- l1_in  input  1  layer select sampled with start: 1 = layer 1, 0 = layer 2.
- act  input  WORD_W  packed binary activations (1 = +1, 0 = -1).
- wgt  input  WORD_W  packed binary weights, same encoding.
- in_valid  input  1  act/wgt beat valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- l1  output  1  layer flag of the current/last result; drives mux select.
- accum1  output  15  layer-1 result, two's complement.
- accum2  output  7  layer-2 result, two's complement, saturated.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result when out_valid & out_ready.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: latch l1_in into l1, clear sum and beat counter, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Per accepted beat: sum += 2*popcount(~(act ^ wgt)) - WORD_W. The per-beat range is -16..+16.
  - Beat counter increments on each accepted beat.
  - On the accepted beat where count == (l1 ? L1_BEATS : L2_BEATS) - 1, go to DONE.
  - Cycles with in_valid=0 change nothing.
- DONE:
  - out_valid=1, in_ready=0.
  - On out_ready, go to IDLE.
- Output registers are loaded on the ACCUM->DONE transition:
  - if l1=1: accum1 <= sum, and accum2 holds its previous value;
  - if l1=0: accum2 <= sat7(sum), and accum1 holds its previous value.
- sat7 saturation rule: sum > 63 -> 7'h3F (+63); sum < -64 -> 7'h40 (-64); otherwise sum[6:0].
- Internal sum is 15-bit signed. Layer-1 magnitude is at most 784, so accum1 is never saturated.
- start is ignored outside IDLE; l1_in is ignored except with start in IDLE.
- accum1, accum2 and l1 remain stable from DONE until the next ACCUM->DONE transition.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, l1=0, accum1=0, accum2=0, sum=0, counter=0.
- rst asserted in any state (including mid-ACCUM or DONE) aborts immediately. The partial sum is discarded and no out_valid is produced.
- start in cycle t -> in_ready=1 from cycle t+1.
- Last beat accepted in cycle t -> out_valid=1 and results valid in cycle t+1. in_ready=0 in cycle t+1.
- out_valid & out_ready in cycle t -> IDLE in t+1. start is accepted in t+1 at the earliest.
- Minimum neuron period is BEATS + 2 cycles (start, BEATS beats, one DONE cycle with out_ready=1).
- out_valid may be held indefinitely by out_ready=0; outputs do not change while held.

## Test plan
- Reset:
  - Stimulus: assert rst mid-cycle with no clk edge.
  - Required response: in_ready=0, out_valid=0, accum1=0, accum2=0, l1=0 immediately.
- Layer 1, all agree:
  - Stimulus: start with l1_in=1; 49 beats act=wgt=16'hFFFF, in_valid held high.
  - Required response: out_valid rises exactly 1 cycle after the 49th beat; accum1=15'd784; l1=1; accum2 unchanged (0).
- Layer 1, all disagree, with bubbles:
  - Stimulus: start with l1_in=1; 49 beats act=16'h0000, wgt=16'hFFFF; in_valid toggled every other cycle.
  - Required response: accum1=15'h7CF0 (-784); exactly 49 beats are accepted.
- Layer 2, normal and saturated:
  - Stimulus (a): 3 beats act=wgt=16'hFFFF. Required response: accum2=7'd48, accum1 retains its previous value.
  - Stimulus (b): with L2_BEATS=5, all-agree beats. Required response: accum2=7'h3F.
  - Stimulus (c): with L2_BEATS=5, all-disagree beats. Required response: accum2=7'h40.
  - Stimulus (d): 3 beats act=16'h00FF, wgt=16'h0000. Required response: accum2=0.
- Backpressure and ignored start:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE; pulse start with l1_in=0 during both ACCUM and DONE.
  - Required response: out_valid, accum1 and l1 stay stable; the stray start causes no restart or layer change.
- Reset mid-operation:
  - Stimulus: assert rst after 10 layer-1 beats, then run a fresh layer-1 neuron with all-agree beats.
  - Required response: no out_valid for the aborted run; the fresh run gives accum1=784.
